key_encoder: RTL and testbench

KEY_ENCODER -- requirements
Module: key_encoder

---
 rtl/key_encoder_pkg.sv | 41 ++++
 rtl/key_sync.sv | 30 +++
 rtl/key_encoder.sv | 159 +++++++++++++++
 tb/tb_key_encoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/key_encoder_pkg.sv
`default_nettype none
// key_encoder_pkg: shared types and constants for the pushbutton encoder.
// Rev 1.0
package key_encoder_pkg;

  localparam int NUM_KEYS = 4;
  localparam int DIGITS_W = 16;
  localparam int CNT_W    = 16;

  localparam logic [3:0] CODE_KEY0 = 4'd0;
  localparam logic [3:0] CODE_KEY1 = 4'd1;
  localparam logic [3:0] CODE_KEY2 = 4'd2;
  localparam logic [3:0] CODE_KEY3 = 4'd3;
  localparam logic [3:0] CODE_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [3:0] key_code(input logic [NUM_KEYS-1:0] v);
    logic [3:0] code;
    code = CODE_NONE;
    case (v)
      4'b0001: code = CODE_KEY0;
      4'b0010: code = CODE_KEY1;
      4'b0100: code = CODE_KEY2;
      4'b1000: code = CODE_KEY3;
      default: code = CODE_NONE;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_sync.sv
`default_nettype none
// key_sync: two-flop synchronizer for the raw active-low pushbuttons.
// Rev 1.0
module key_sync
  import key_encoder_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] keys_n_i,
  output logic [NUM_KEYS-1:0] keys_n_o
);

  logic [NUM_KEYS-1:0] meta_q;
  logic [NUM_KEYS-1:0] sync_q;

  // Reset to all-ones: a released active-low button reads high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= keys_n_i;
      sync_q <= meta_q;
    end
  end

  assign keys_n_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/key_encoder.sv
`default_nettype none
// key_encoder: debounces four pushbuttons, encodes single presses, keeps last four codes.
// Rev 1.0
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  input  logic                KEY0,
  input  logic                KEY1,
  input  logic                KEY2,
  input  logic                KEY3,
  input  logic                CLR,
  output logic [3:0]          Code,
  output logic                Code_valid,
  output logic                Err,
  output logic [DIGITS_W-1:0] Digits,
  output logic [2:0]          Count,
  output logic                Full
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] keys_n_sync;
  logic [NUM_KEYS-1:0] press;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]  v_q, v_d;
  logic [3:0]           code_q, code_d;
  logic                 code_valid_q, code_valid_d;
  logic                 err_q, err_d;
  logic [DIGITS_W-1:0]  digits_q, digits_d;
  logic [2:0]           count_q, count_d;
  logic                 qualified;

  key_sync u_key_sync (
    .clk_i    (CLOCK_50),
    .rst_i    (RST),
    .keys_n_i ({KEY3, KEY2, KEY1, KEY0}),
    .keys_n_o (keys_n_sync)
  );

  assign press = ~keys_n_sync;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    v_d       = v_q;
    qualified = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press != '0) begin
          v_d     = press;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (press == v_q) begin
          if (cnt_q == C_LAST) begin
            state_d   = ST_HELD;
            qualified = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (press == '0) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          // A different key pattern restarts qualification on the new vector.
          v_d   = press;
          cnt_d = '0;
        end
      end
      ST_HELD: begin
        if (press == '0) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (press != '0) begin
          state_d = ST_HELD;
        end else if (cnt_q == C_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    code_d       = code_q;
    code_valid_d = 1'b0;
    err_d        = 1'b0;
    if (qualified) begin
      if (is_onehot(v_q)) begin
        code_d       = key_code(v_q);
        code_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // The buffer reacts to the registered Code_valid so that CLR in the same cycle wins.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (CLR) begin
      digits_d = '0;
      count_d  = '0;
    end else if (code_valid_q) begin
      digits_d = {digits_q[DIGITS_W-5:0], code_q};
      count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      code_q       <= CODE_NONE;
      code_valid_q <= 1'b0;
      err_q        <= 1'b0;
      digits_q     <= '0;
      count_q      <= '0;
    end else begin
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      err_q        <= err_d;
      digits_q     <= digits_d;
      count_q      <= count_d;
    end
  end

  assign Code       = code_q;
  assign Code_valid = code_valid_q;
  assign Err        = err_q;
  assign Digits     = digits_q;
  assign Count      = count_q;
  assign Full       = (count_q == 3'd4);

endmodule
`default_nettype wire

// File: tb/tb_key_encoder.sv
`default_nettype none
// tb_key_encoder: scoreboard bench for key_encoder with DEBOUNCE_CYCLES = 4.
// Rev 1.0
module tb_key_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        k0 = 1'b1, k1 = 1'b1, k2 = 1'b1, k3 = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  Code;
  logic        Code_valid;
  logic        Err;
  logic [15:0] Digits;
  logic [2:0]  Count;
  logic        Full;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  key_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50   (clk),
    .RST        (rst),
    .KEY0       (k0),
    .KEY1       (k1),
    .KEY2       (k2),
    .KEY3       (k3),
    .CLR        (clr),
    .Code       (Code),
    .Code_valid (Code_valid),
    .Err        (Err),
    .Digits     (Digits),
    .Count      (Count),
    .Full       (Full)
  );

  always #5 clk = ~clk;

  task automatic set_keys(input logic [3:0] pressed);
    {k3, k2, k1, k0} = ~pressed;
  endtask

  // Observes a bounded window; records first-pulse latency, pulse counts and the code seen.
  task automatic watch(input int cycles, output int lat, output int cv_n, output int err_n,
                       output logic [3:0] seen);
    lat = -1; cv_n = 0; err_n = 0; seen = 4'hx;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (Code_valid === 1'b1) begin
        cv_n++;
        if (lat < 0) begin lat = i; seen = Code; end
      end
      if (Err === 1'b1) err_n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; set_keys(4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; set_keys(4'b0000);
    repeat (2) @(negedge clk);
    checks++; if (Code !== 4'hF) begin errors++; $display("FAIL reset_code: got %h expected %h", Code, 4'hF); end
    checks++; if (Code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Code_valid); end
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", Err); end
    checks++; if (Digits !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h expected 0000", Digits); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", Count); end
    checks++; if (Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", Full); end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int lat, cv, er; logic [3:0] seen, exp;
    do_reset();
    exp_q.push_back(4'd2);
    set_keys(4'b0100);
    watch(20, lat, cv, er, seen);
    exp = exp_q.pop_front();
    checks++; if (lat !== 7) begin errors++; $display("FAIL clean_latency: got %0d expected 7", lat); end
    checks++; if (cv !== 1) begin errors++; $display("FAIL clean_pulses: got %0d expected 1", cv); end
    checks++; if (er !== 0) begin errors++; $display("FAIL clean_err: got %0d expected 0", er); end
    checks++; if (seen !== exp) begin errors++; $display("FAIL clean_code: got %h expected %h", seen, exp); end
    checks++; if (Digits !== 16'h0002) begin errors++; $display("FAIL clean_digits: got %h expected 0002", Digits); end
    checks++; if (Count !== 3'd1) begin errors++; $display("FAIL clean_count: got %0d expected 1", Count); end
    set_keys(4'b0000);
    watch(12, lat, cv, er, seen);
    checks++; if (cv + er !== 0) begin errors++; $display("FAIL release_pulses: got %0d expected 0", cv + er); end
  endtask

  task automatic test_bounce();
    int lat, cv, er; logic [3:0] seen, exp;
    do_reset();
    exp_q.push_back(4'd1);
    set_keys(4'b0010); @(negedge clk);
    set_keys(4'b0000); @(negedge clk);
    set_keys(4'b0010);
    watch(20, lat, cv, er, seen);
    exp = exp_q.pop_front();
    checks++; if (cv !== 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", cv); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL bounce_latency: got %0d expected 7", lat); end
    checks++; if (seen !== exp) begin errors++; $display("FAIL bounce_code: got %h expected %h", seen, exp); end
    set_keys(4'b0000);
    watch(12, lat, cv, er, seen);
  endtask

  task automatic test_multi_key();
    int lat, cv, er; logic [3:0] seen, exp;
    do_reset();
    set_keys(4'b1001);
    watch(10, lat, cv, er, seen);
    checks++; if (er !== 1) begin errors++; $display("FAIL multi_err: got %0d expected 1", er); end
    checks++; if (cv !== 0) begin errors++; $display("FAIL multi_valid: got %0d expected 0", cv); end
    checks++; if (Code !== 4'hF) begin errors++; $display("FAIL multi_code: got %h expected F", Code); end
    set_keys(4'b0000);
    watch(12, lat, cv, er, seen);
    exp_q.push_back(4'd3);
    set_keys(4'b1000);
    watch(15, lat, cv, er, seen);
    exp = exp_q.pop_front();
    checks++; if (cv !== 1 || lat !== 7) begin errors++; $display("FAIL multi_key3: got pulses=%0d lat=%0d expected 1 and 7", cv, lat); end
    checks++; if (seen !== exp) begin errors++; $display("FAIL multi_key3_code: got %h expected %h", seen, exp); end
    set_keys(4'b0000);
    watch(12, lat, cv, er, seen);
  endtask

  task automatic test_fill();
    int lat, cv, er; logic [3:0] seen, exp;
    logic [15:0] m_digits;
    int m_count;
    int keys[5] = '{0, 1, 2, 3, 0};
    do_reset();
    m_digits = 16'h0000; m_count = 0;
    foreach (keys[n]) begin
      exp_q.push_back(4'(keys[n]));
      set_keys(4'(1 << keys[n]));
      watch(12, lat, cv, er, seen);
      exp = exp_q.pop_front();
      checks++; if (seen !== exp) begin errors++; $display("FAIL fill_code%0d: got %h expected %h", n, seen, exp); end
      m_digits = {m_digits[11:0], exp};
      m_count  = (m_count == 4) ? 4 : m_count + 1;
      set_keys(4'b0000);
      watch(12, lat, cv, er, seen);
      checks++; if (Digits !== m_digits) begin errors++; $display("FAIL fill_digits%0d: got %h expected %h", n, Digits, m_digits); end
      checks++; if (Count !== 3'(m_count)) begin errors++; $display("FAIL fill_count%0d: got %0d expected %0d", n, Count, m_count); end
      checks++; if (Full !== (m_count == 4)) begin errors++; $display("FAIL fill_full%0d: got %b expected %b", n, Full, m_count == 4); end
    end
    checks++; if (Digits !== 16'h1230) begin errors++; $display("FAIL fill_final: got %h expected 1230", Digits); end
  endtask

  task automatic test_clr_collision();
    int lat, cv, er; logic [3:0] seen, exp;
    bit hit;
    do_reset();
    exp_q.push_back(4'd1);
    set_keys(4'b0010);
    watch(12, lat, cv, er, seen);
    exp = exp_q.pop_front();
    checks++; if (seen !== exp) begin errors++; $display("FAIL clr_pre_code: got %h expected %h", seen, exp); end
    set_keys(4'b0000);
    watch(12, lat, cv, er, seen);
    exp_q.push_back(4'd2);
    set_keys(4'b0100);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (Code_valid === 1'b1) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL clr_timeout: got no Code_valid expected one within 20 cycles"); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (Code !== exp) begin errors++; $display("FAIL clr_code: got %h expected %h", Code, exp); end
    checks++; if (Digits !== 16'h0000) begin errors++; $display("FAIL clr_digits: got %h expected 0000", Digits); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", Count); end
    watch(8, lat, cv, er, seen);
    checks++; if (cv !== 0 || Digits !== 16'h0000) begin errors++; $display("FAIL clr_after: got pulses=%0d digits=%h expected 0 and 0000", cv, Digits); end
    set_keys(4'b0000);
    watch(12, lat, cv, er, seen);
  endtask

  task automatic test_reset_mid_debounce();
    int lat, cv, er, cv_rst; logic [3:0] seen, exp;
    do_reset();
    set_keys(4'b0010);
    watch(5, lat, cv, er, seen);
    rst = 1'b1;
    watch(2, lat, cv_rst, er, seen);
    rst = 1'b0;
    checks++; if (cv + cv_rst !== 0) begin errors++; $display("FAIL rst_early_pulse: got %0d expected 0", cv + cv_rst); end
    exp_q.push_back(4'd1);
    watch(20, lat, cv, er, seen);
    exp = exp_q.pop_front();
    checks++; if (lat !== 7) begin errors++; $display("FAIL rst_latency: got %0d expected 7", lat); end
    checks++; if (cv !== 1) begin errors++; $display("FAIL rst_pulses: got %0d expected 1", cv); end
    checks++; if (seen !== exp) begin errors++; $display("FAIL rst_code: got %h expected %h", seen, exp); end
    set_keys(4'b0000);
    watch(12, lat, cv, er, seen);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_fill();
    test_clr_collision();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
